// File: rtl/data_memory_hs.sv
// Single-port 32-bit data memory with valid/ready request handshake, sub-word
// loads with sign/zero extension, and read-modify-write byte/half stores.
module data_memory_hs #(
  parameter int unsigned DEPTH         = 1024,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_mask,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {INIT, IDLE, RD_RESP, RMW_WR, WR_RESP} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] init_cnt;
  logic [AW-1:0] a_idx;
  logic [1:0]    a_lane;
  logic [2:0]    a_mask;
  logic [15:0]   a_wdata;
  logic [31:0]   rd_word;
  logic          rd_ok;

  logic          accept;
  logic [AW-1:0] req_idx;
  logic          is_byte, is_half, is_word, req_err;
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;
  logic [31:0]   merged;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  assign accept  = req_valid && req_ready;
  assign req_idx = req_addr[AW+1:2];

  always_comb begin
    is_byte = (req_mask[1:0] == 2'b00);
    is_half = (req_mask[1:0] == 2'b01);
    is_word = (req_mask == 3'b010);
    req_err = !(is_byte || is_half || is_word)
           || (req_we && req_mask[2])
           || (is_half && req_addr[0])
           || (is_word && (req_addr[1:0] != 2'b00))
           || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
  end

  // Old word with the addressed byte or half lane replaced by the store data.
  always_comb begin
    merged = rd_word;
    if (a_mask[0] == 1'b0)
      merged[{a_lane, 3'b000} +: 8] = a_wdata[7:0];
    else
      merged[{a_lane[1], 4'b0000} +: 16] = a_wdata;
  end

  always_comb begin
    sel_byte = rd_word[{a_lane, 3'b000} +: 8];
    sel_half = rd_word[{a_lane[1], 4'b0000} +: 16];
    case (a_mask)
      3'b000:  resp_rdata = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  resp_rdata = {24'h0, sel_byte};
      3'b001:  resp_rdata = {{16{sel_half[15]}}, sel_half};
      3'b101:  resp_rdata = {16'h0, sel_half};
      default: resp_rdata = rd_word;
    endcase
    if (!rd_ok)
      resp_rdata = '0;
  end

  // Writes are gated by reset so an aborted RMW never reaches the array.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = init_cnt;
    mem_wdata = '0;
    if (!reset) begin
      case (state)
        INIT: mem_we = 1'b1;
        IDLE: if (accept && !req_err && req_we && is_word) begin
          mem_we    = 1'b1;
          mem_widx  = req_idx;
          mem_wdata = req_wdata;
        end
        RMW_WR: begin
          mem_we    = 1'b1;
          mem_widx  = a_idx;
          mem_wdata = merged;
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_widx] <= mem_wdata;
    if (accept)
      rd_word <= mem[req_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT_ON_RESET ? INIT : IDLE;
      init_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rd_ok      <= 1'b0;
      req_ready  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == AW'(DEPTH - 1)) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready <= 1'b0;
            a_idx     <= req_idx;
            a_lane    <= req_addr[1:0];
            a_mask    <= req_mask;
            a_wdata   <= req_wdata[15:0];
            if (req_err) begin
              state      <= RD_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (!req_we) begin
              state      <= RD_RESP;
              resp_valid <= 1'b1;
              rd_ok      <= 1'b1;
            end else if (is_word) begin
              state      <= WR_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= RMW_WR;
            end
          end
        end
        RMW_WR: begin
          state      <= WR_RESP;
          resp_valid <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          rd_ok      <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: directed vector table, randomized requests against
// an array reference model, reset-abort and back-to-back handshake sequences.
module tb_data_memory_hs;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_mask = 3'b010;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_model [DEPTH];

  data_memory_hs #(.DEPTH(DEPTH), .INIT_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mask(req_mask), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [2:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit we, logic [2:0] mask, logic [31:0] addr,
                             logic [31:0] wd, logic [31:0] rd, bit err, int lat);
    vec_t r;
    r.we = we; r.mask = mask; r.addr = addr; r.wdata = wd;
    r.exp_rd = rd; r.exp_err = err; r.exp_lat = lat;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on a word array.
  function automatic void model(input bit we, input logic [2:0] mask, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output bit err, output int lat);
    int unsigned w = addr / 4;
    int unsigned lane = addr % 4;
    bit is_b = (mask == 3'd0) || (mask == 3'd4);
    bit is_h = (mask == 3'd1) || (mask == 3'd5);
    bit is_w = (mask == 3'd2);
    logic [31:0] part;
    rd = '0;
    lat = 1;
    err = !(is_b || is_h || is_w) || (we && mask >= 3'd4) || (is_h && addr % 2 != 0)
       || (is_w && addr % 4 != 0) || (w >= DEPTH);
    if (err) return;
    if (we) begin
      if (is_w) mem_model[w] = wd;
      else if (is_b) begin
        mem_model[w] = (mem_model[w] & ~(32'hFF << (8 * lane))) | ((wd & 32'hFF) << (8 * lane));
        lat = 2;
      end else begin
        mem_model[w] = (mem_model[w] & ~(32'hFFFF << (8 * lane))) | ((wd & 32'hFFFF) << (8 * lane));
        lat = 2;
      end
    end else begin
      if (is_w) rd = mem_model[w];
      else if (is_b) begin
        part = (mem_model[w] >> (8 * lane)) & 32'hFF;
        rd = (mask == 3'd0 && part >= 128) ? part + 32'hFFFF_FF00 : part;
      end else begin
        part = (mem_model[w] >> (8 * lane)) & 32'hFFFF;
        rd = (mask == 3'd1 && part >= 32768) ? part + 32'hFFFF_0000 : part;
      end
    end
  endfunction

  task automatic do_req(input bit we, input logic [2:0] mask, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat);
    int w = 0;
    rd = '0; err = 1'b0; lat = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin w++; @(negedge clk); end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      return;
    end
    req_valid = 1'b1; req_we = we; req_mask = mask; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        rd = resp_rdata; err = resp_err; lat = c;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL resp_timeout: got none expected resp_valid");
  endtask

  task automatic count_ready_low(output int cnt, output int resps);
    cnt = 0; resps = 0;
    while (!req_ready && cnt < 100) begin
      if (resp_valid) resps++;
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, exp_rd;
    logic        err;
    bit          exp_err;
    int          lat, exp_lat, cnt, resps, acc, last_wd, k_we;
    logic [2:0]  masks [8];
    logic [2:0]  m;

    masks = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;

    tbl.push_back(v(1, 3'b010, 32'h8, 32'h8000_00FF, 32'h0,         0, 1));
    tbl.push_back(v(0, 3'b000, 32'h8, 32'h0,         32'hFFFF_FFFF, 0, 1));
    tbl.push_back(v(0, 3'b100, 32'h8, 32'h0,         32'h0000_00FF, 0, 1));
    tbl.push_back(v(0, 3'b001, 32'hA, 32'h0,         32'hFFFF_8000, 0, 1));
    tbl.push_back(v(0, 3'b010, 32'h8, 32'h0,         32'h8000_00FF, 0, 1));
    tbl.push_back(v(1, 3'b010, 32'h4, 32'h1122_3344, 32'h0,         0, 1));
    tbl.push_back(v(1, 3'b000, 32'h6, 32'h0000_00AB, 32'h0,         0, 2));
    tbl.push_back(v(0, 3'b010, 32'h4, 32'h0,         32'h11AB_3344, 0, 1));
    tbl.push_back(v(1, 3'b001, 32'h4, 32'h0000_BEEF, 32'h0,         0, 2));
    tbl.push_back(v(0, 3'b010, 32'h4, 32'h0,         32'h11AB_BEEF, 0, 1));
    tbl.push_back(v(0, 3'b101, 32'h6, 32'h0,         32'h0000_11AB, 0, 1));
    tbl.push_back(v(0, 3'b010, 32'h2, 32'h0,         32'h0,         1, 1));
    tbl.push_back(v(1, 3'b001, 32'h1, 32'h1234,      32'h0,         1, 1));
    tbl.push_back(v(0, 3'b011, 32'h4, 32'h0,         32'h0,         1, 1));
    tbl.push_back(v(1, 3'b100, 32'h4, 32'h77,        32'h0,         1, 1));
    tbl.push_back(v(0, 3'b010, 32'h40, 32'h0,        32'h0,         1, 1));
    tbl.push_back(v(1, 3'b010, 32'h40, 32'hDEAD_BEEF, 32'h0,        1, 1));
    tbl.push_back(v(0, 3'b010, 32'h4, 32'h0,         32'h11AB_BEEF, 0, 1));
    tbl.push_back(v(0, 3'b010, 32'h8, 32'h0,         32'h8000_00FF, 0, 1));
    tbl.push_back(v(0, 3'b000, 32'hB, 32'h0,         32'hFFFF_FF80, 0, 1));
    tbl.push_back(v(0, 3'b100, 32'hB, 32'h0,         32'h0000_0080, 0, 1));

    // Reset for one cycle, then INIT must hold req_ready low for DEPTH cycles.
    @(posedge clk);
    #1 reset = 1'b0;
    check("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("reset_resp_err", {31'b0, resp_err}, 32'h0);
    check("reset_resp_rdata", resp_rdata, 32'h0);
    count_ready_low(cnt, resps);
    check("init_ready_low_cycles", cnt, DEPTH);

    for (int i = 0; i < DEPTH; i++) begin
      do_req(0, 3'b010, 32'(i * 4), 32'h0, rd, err, lat);
      check("init_zero_rdata", rd, 32'h0);
      check("init_zero_err", {31'b0, err}, 32'h0);
    end

    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].mask, tbl[i].addr, tbl[i].wdata, exp_rd, exp_err, exp_lat);
      do_req(tbl[i].we, tbl[i].mask, tbl[i].addr, tbl[i].wdata, rd, err, lat);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
      check($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
    end

    for (int i = 0; i < 300; i++) begin
      int sel;
      logic [31:0] a, wd;
      bit we;
      sel = $urandom_range(0, 9);
      m = (sel > 7) ? 3'd2 : masks[sel];
      we = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, DEPTH + 3) * 4 + $urandom_range(0, 3));
      wd = $urandom;
      model(we, m, a, wd, exp_rd, exp_err, exp_lat);
      do_req(we, m, a, wd, rd, err, lat);
      check("rand_rdata", rd, exp_rd);
      check("rand_err", {31'b0, err}, {31'b0, exp_err});
      check("rand_lat", lat, exp_lat);
    end

    // Reset while the RMW write is pending: no response, INIT restarts.
    do_req(1, 3'b010, 32'h0, 32'h0, rd, err, lat);
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_mask = 3'b000; req_addr = 32'h0; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    resps = resp_valid ? 1 : 0;
    @(posedge clk);
    #1 reset = 1'b0;
    begin
      int r2;
      count_ready_low(cnt, r2);
      resps += r2;
    end
    check("abort_no_resp", resps, 0);
    check("abort_init_cycles", cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    do_req(0, 3'b010, 32'h0, 32'h0, rd, err, lat);
    check("abort_word0", rd, 32'h0);
    do_req(0, 3'b010, 32'h8, 32'h0, rd, err, lat);
    check("abort_word2", rd, 32'h0);

    // Back-to-back: req_valid held high, alternating lw/sw at 0xC.
    @(negedge clk);
    acc = 0; resps = 0; last_wd = 0; k_we = 0;
    req_valid = 1'b1; req_we = 1'b0; req_mask = 3'b010; req_addr = 32'hC; req_wdata = '0;
    for (int k = 0; k < 40; k++) begin
      bit fire;
      if (resp_valid) resps++;
      fire = req_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        acc++;
        if (req_we) last_wd = int'(req_wdata);
        k_we = 1 - k_we;
        req_we = 1'(k_we);
        req_wdata = 32'(k + 100);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (3) begin
      if (resp_valid) resps++;
      @(negedge clk);
    end
    check("b2b_accepts", acc, 20);
    check("b2b_resp_eq_accept", resps, acc);
    mem_model[3] = 32'(last_wd);
    model(0, 3'b010, 32'hC, 32'h0, exp_rd, exp_err, exp_lat);
    do_req(0, 3'b010, 32'hC, 32'h0, rd, err, lat);
    check("b2b_last_store", rd, exp_rd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
